// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Registered program-counter generator for the Fetch stage with
//            boot cycle, stall hold, redirect and misaligned-target fault.
//            Optional trap entry is enabled by defining PC_GEN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int unsigned               DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]     RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned               INC_BYTES    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
`ifdef PC_GEN_TRAP_EN
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_vector_i,
`endif
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus_inc_o,
    output logic                  pc_valid_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] misalign_addr_o
);

    localparam logic [DATA_WIDTH-1:0] c_inc        = DATA_WIDTH'(INC_BYTES);
    localparam logic [DATA_WIDTH-1:0] c_align_mask = DATA_WIDTH'(INC_BYTES - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic                  r_misalign;
    logic                  w_fault;
    logic [DATA_WIDTH-1:0] r_maddr;
    logic [DATA_WIDTH-1:0] w_maddr_next;
    logic                  w_target_misaligned;
    logic                  w_trap;
    logic [DATA_WIDTH-1:0] w_trap_pc;

    assign w_target_misaligned = |(redirect_target_i & c_align_mask);

`ifdef PC_GEN_TRAP_EN
    assign w_trap    = trap_i;
    assign w_trap_pc = trap_vector_i & ~c_align_mask;
`else
    assign w_trap    = 1'b0;
    assign w_trap_pc = '0;
`endif

    // Priority in RUN/FAULT: trap > redirect > stall > sequential.
    // FAULT never advances on its own; only a redirect or trap leaves it.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_fault      = 1'b0;
        w_maddr_next = r_maddr;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN, ST_FAULT: begin
                if (w_trap) begin
                    w_pc_next    = w_trap_pc;
                    w_state_next = ST_RUN;
                end else if (redirect_i) begin
                    if (w_target_misaligned) begin
                        w_fault      = 1'b1;
                        w_maddr_next = redirect_target_i;
                        w_state_next = ST_FAULT;
                    end else begin
                        w_pc_next    = redirect_target_i;
                        w_state_next = ST_RUN;
                    end
                end else if (!stall_i && (r_state == ST_RUN)) begin
                    w_pc_next = r_pc + c_inc;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
                w_pc_next    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_misalign <= 1'b0;
            r_maddr    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_misalign <= w_fault;
            r_maddr    <= w_maddr_next;
        end
    end

    assign pc_o            = r_pc;
    assign pc_plus_inc_o   = r_pc + c_inc;
    assign pc_valid_o      = (r_state == ST_RUN);
    assign misalign_o      = r_misalign;
    assign misalign_addr_o = r_maddr;

endmodule
`default_nettype wire
